// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory model: controller states,
// default geometry/latency and the wait-counter width.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_DEPTH = 4096;
  localparam int DEFAULT_WAIT  = 4;
  localparam int CNT_W         = 4;
  localparam int DATA_W        = 32;

  // Value loaded into the wait counter on acceptance; the access commits on
  // the edge where the counter is already zero, i.e. wait_states edges later.
  function automatic logic [CNT_W-1:0] wait_load(input int wait_states);
    return CNT_W'(wait_states - 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with a registered read port.
// Only the read-data register is reset; the storage array keeps its contents.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // The read register holds the last completed read between accesses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/main_memory.sv
// Fixed-latency word-addressed main memory on the cache M-side bus.
// A strobe accepted in IDLE commits WAIT edges later; MReady pulses the cycle after.
module main_memory
  import mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WAIT  = DEFAULT_WAIT
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [31:0]       MAddress,
  input  logic [DATA_W-1:0] MDataIn,
  output logic [DATA_W-1:0] MDataOut,
  output logic              MReady,
  output logic              MBusy
);

  localparam int AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_rw_q, req_rw_d;
  logic [AW-1:0]     req_idx_q, req_idx_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              commit;
  logic              ram_we;
  logic              ram_re;

  // Byte offset and the address bits above the array alias away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{MAddress[31:AW+2], MAddress[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_rw_d   = req_rw_q;
    req_idx_d  = req_idx_q;
    req_data_d = req_data_q;
    ready_d    = 1'b0;
    commit     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (MStrobe) begin
          state_d    = BUSY;
          cnt_d      = wait_load(WAIT);
          req_rw_d   = MRW;
          req_idx_d  = MAddress[AW+1:2];
          req_data_d = MDataIn;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Reset wins over a commit on the same edge, so the RAM strobes are gated by it.
  assign ram_we = commit & ~req_rw_q & Reset;
  assign ram_re = commit &  req_rw_q & Reset;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_rw_q   <= 1'b0;
      req_idx_q  <= '0;
      req_data_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_rw_q   <= req_rw_d;
      req_idx_q  <= req_idx_d;
      req_data_q <= req_data_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem_array (
    .clk   (clk),
    .rst_n (Reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (req_idx_q),
    .wdata (req_data_q),
    .rdata (MDataOut)
  );

  assign MReady = ready_q;
  assign MBusy  = busy_q;

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: directed scenarios plus randomized
// accesses checked against a word-indexed reference memory.
module tb_main_memory;

  localparam int DEPTH  = 4096;
  localparam int WAIT_A = 4;
  localparam int WAIT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, strobe_a, rw_a, ready_a, busy_a;
  logic [31:0] addr_a, din_a, dout_a;
  logic        reset_b, strobe_b, rw_b, ready_b, busy_b;
  logic [31:0] addr_b, din_b, dout_b;

  main_memory #(.DEPTH(DEPTH), .WAIT(WAIT_A)) dut (
    .clk      (clk),
    .Reset    (reset_a),
    .MStrobe  (strobe_a),
    .MRW      (rw_a),
    .MAddress (addr_a),
    .MDataIn  (din_a),
    .MDataOut (dout_a),
    .MReady   (ready_a),
    .MBusy    (busy_a)
  );

  main_memory #(.DEPTH(DEPTH), .WAIT(WAIT_B)) dut_fast (
    .clk      (clk),
    .Reset    (reset_b),
    .MStrobe  (strobe_b),
    .MRW      (rw_b),
    .MAddress (addr_b),
    .MDataIn  (din_b),
    .MDataOut (dout_b),
    .MReady   (ready_b),
    .MBusy    (busy_b)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model [int];
  logic [31:0] last_read = 32'h0;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int wordIdx(input logic [31:0] a);
    return int'((a / 32'd4) % DEPTH);
  endfunction

  // Called at the negedge of the first cycle after acceptance; checks timing to MReady.
  task automatic waitDone(input string tag, input logic was_write, output logic [31:0] rdata_obs);
    int lat;
    lat = 1;
    checkOutput({tag, "_busy_c1"}, 32'(busy_a), 32'd1);
    while (ready_a !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(WAIT_A + 1));
    checkOutput({tag, "_busy_at_ready"}, 32'(busy_a), 32'd1);
    rdata_obs = dout_a;
    if (was_write) checkOutput({tag, "_dout_hold"}, dout_a, last_read);
    @(negedge clk);
    checkOutput({tag, "_ready_drop"}, 32'(ready_a), 32'd0);
    checkOutput({tag, "_busy_drop"}, 32'(busy_a), 32'd0);
  endtask

  task automatic applyStimulus(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                               input string tag, output logic [31:0] rdata_obs);
    @(negedge clk);
    strobe_a = 1'b1;
    rw_a     = rw;
    addr_a   = addr;
    din_a    = data;
    @(posedge clk);
    @(negedge clk);
    strobe_a = 1'b0;
    rw_a     = 1'($urandom);
    addr_a   = $urandom;
    din_a    = $urandom;
    waitDone(tag, !rw, rdata_obs);
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input string tag);
    logic [31:0] obs;
    applyStimulus(1'b0, addr, data, tag, obs);
    model[wordIdx(addr)] = data;
  endtask

  task automatic doRead(input logic [31:0] addr, input string tag, output logic [31:0] obs);
    applyStimulus(1'b1, addr, $urandom, tag, obs);
    if (model.exists(wordIdx(addr))) checkOutput({tag, "_data"}, obs, model[wordIdx(addr)]);
    else checkOutput({tag, "_known"}, 32'd0, 32'd1);
    last_read = obs;
  endtask

  initial begin
    logic [31:0] obs;
    logic [31:0] rd_busy;
    int          pulses;
    int          pool [6];
    int          lat;

    reset_a = 1'b0; strobe_a = 1'b1; rw_a = 1'b0; addr_a = 32'h100; din_a = 32'hDEADBEEF;
    reset_b = 1'b0; strobe_b = 1'b0; rw_b = 1'b0; addr_b = 32'h0;   din_b = 32'h0;

    // Reset held two cycles with a strobe pending: nothing may start.
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_ready", 32'(ready_a), 32'd0);
      checkOutput("rst_busy", 32'(busy_a), 32'd0);
      checkOutput("rst_dout", dout_a, 32'd0);
    end
    reset_a = 1'b1;
    reset_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    strobe_a = 1'b0;
    waitDone("rst_release_wr", 1'b1, obs);
    model[wordIdx(32'h100)] = 32'hDEADBEEF;

    doRead(32'h100, "rd_100", obs);
    checkOutput("rd_100_const", obs, 32'hDEADBEEF);

    // Reset again with nonzero read data held: MDataOut must clear.
    @(negedge clk);
    reset_a = 1'b0; strobe_a = 1'b1; rw_a = 1'b1; addr_a = 32'h100;
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst2_ready", 32'(ready_a), 32'd0);
      checkOutput("rst2_busy", 32'(busy_a), 32'd0);
      checkOutput("rst2_dout", dout_a, 32'd0);
    end
    reset_a = 1'b1; strobe_a = 1'b0;
    last_read = 32'h0;
    @(negedge clk);
    checkOutput("rst2_idle", 32'(busy_a), 32'd0);

    doWrite(32'h0000_4004, 32'h12345678, "alias_wr");
    doRead(32'h0000_0004, "alias_rd4", obs);
    checkOutput("alias_rd4_const", obs, 32'h12345678);
    doRead(32'h0000_0007, "alias_rd7", obs);
    checkOutput("alias_rd7_const", obs, 32'h12345678);

    // A write strobe during BUSY must be ignored.
    doWrite(32'h10, 32'hCAFE0010, "busy_pre_wr");
    @(negedge clk);
    strobe_a = 1'b1; rw_a = 1'b1; addr_a = 32'h10;
    @(posedge clk);
    pulses = 0; rd_busy = 32'h0;
    for (int k = 1; k <= WAIT_A + 6; k++) begin
      @(negedge clk);
      if (ready_a) begin
        pulses++;
        rd_busy = dout_a;
      end
      if (k == 1) strobe_a = 1'b0;
      if (k == 2) begin
        strobe_a = 1'b1; rw_a = 1'b0; addr_a = 32'h10; din_a = 32'h0BADF00D;
      end
      if (k == 3) strobe_a = 1'b0;
    end
    checkOutput("busy_strobe_pulses", 32'(pulses), 32'd1);
    checkOutput("busy_strobe_rdata", rd_busy, 32'hCAFE0010);
    last_read = rd_busy;
    doRead(32'h10, "busy_strobe_reread", obs);

    // Reset one cycle before (off=1) and exactly at (off=0) the write commit edge.
    for (int off = 1; off >= 0; off--) begin
      doWrite(32'h20, 32'h0000_2020 + 32'(off), "rstmid_pre_wr");
      @(negedge clk);
      strobe_a = 1'b1; rw_a = 1'b0; addr_a = 32'h20; din_a = 32'hA5A5A5A5;
      @(posedge clk);
      pulses = 0;
      for (int k = 1; k <= WAIT_A + 6; k++) begin
        @(negedge clk);
        if (ready_a) pulses++;
        if (k == 1) strobe_a = 1'b0;
        if (k == WAIT_A - off) reset_a = 1'b0;
        if (k == WAIT_A - off + 1) reset_a = 1'b1;
      end
      checkOutput("rstmid_no_ready", 32'(pulses), 32'd0);
      checkOutput("rstmid_busy", 32'(busy_a), 32'd0);
      checkOutput("rstmid_dout", dout_a, 32'd0);
      last_read = 32'h0;
      doRead(32'h20, "rstmid_rd", obs);
    end

    // Randomized traffic with aliased high bits and random byte offsets.
    foreach (pool[i]) begin
      pool[i] = int'($urandom_range(0, DEPTH - 1));
      doWrite(($urandom << 14) | (32'(pool[i]) << 2) | 32'($urandom_range(0, 3)), $urandom, "rnd_init");
    end
    for (int n = 0; n < 24; n++) begin
      int   sel;
      logic [31:0] a;
      sel = int'($urandom_range(0, 5));
      a = ($urandom << 14) | (32'(pool[sel]) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) doRead(a, "rnd_rd", obs);
      else doWrite(a, $urandom, "rnd_wr");
    end

    // Fast instance: strobe held high, one access every WAIT_B+2 cycles.
    @(negedge clk);
    strobe_b = 1'b1; rw_b = 1'b0; addr_b = 32'h40; din_b = 32'h5EED0040;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("b2b_ready", 32'(ready_b), (k % 3 == 1) ? 32'd1 : 32'd0);
      checkOutput("b2b_busy", 32'(busy_b), (k % 3 != 2) ? 32'd1 : 32'd0);
    end
    strobe_b = 1'b0;
    repeat (4) @(negedge clk);
    strobe_b = 1'b1; rw_b = 1'b1; addr_b = 32'h40;
    @(posedge clk);
    @(negedge clk);
    strobe_b = 1'b0;
    lat = 1;
    while (ready_b !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("fast_rd_latency", 32'(lat), 32'(WAIT_B + 1));
    checkOutput("fast_rd_data", dout_b, 32'h5EED0040);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/main_memory.md
# main_memory

Word-addressed main-memory model with a configurable, fixed access latency. It sits directly downstream of the direct-mapped cache and services the cache's miss/write-through traffic on the M-side bus: MStrobe, MRW, MAddress, MDataIn in; MDataOut out. It adds an explicit MReady completion pulse and an MBusy flag so the cache controller can stall on real memory latency instead of a hard-coded wait.

## Interface
- DEPTH, 4096: number of 32-bit words; power of two; AW = log2(DEPTH).
- WAIT, 4: wait states per access; legal range 1..15.

- clk  input  1  clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- MStrobe  input  1  request strobe; sampled only in IDLE.
- MRW  input  1  1 = read, 0 = write; sampled with MStrobe.
- MAddress  input  32  byte address; word index = MAddress[AW+1:2]; bits [1:0] and above AW+1 ignored (aliasing).
- MDataIn  input  32  write data; sampled with MStrobe.
- MDataOut  output  32  read data; registered; holds last completed read.
- MReady  output  1  one-cycle completion pulse, read or write.
- MBusy  output  1  high while a request is in flight (states BUSY and DONE).

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if MStrobe=1 at an edge, latch MRW, word index and MDataIn into request registers, load wait counter with WAIT-1, go to BUSY. Else stay.
- BUSY: decrement counter each edge; when counter = 0 at an edge, perform the access and go to DONE.
  - Read: MDataOut <= array[index] (array read uses the latched index).
  - Write: array[index] <= latched data; MDataOut unchanged.
- DONE: MReady = 1 for this cycle only; next edge goes to IDLE unconditionally.
- MStrobe in BUSY/DONE: ignored; no queueing. The requester holds or re-asserts MStrobe after MReady.
- MStrobe held high across DONE->IDLE: sampled again in IDLE, starting a new access (back-to-back allowed, one idle cycle between MReady and next acceptance).
- Inputs other than Reset are don't-care outside the IDLE sampling edge; changing MAddress/MDataIn mid-access has no effect.
- Reset (Reset=0 at an edge): state <= IDLE, counter <= 0, MReady <= 0, MBusy <= 0, MDataOut <= 32'h0. An in-flight write whose commit edge coincides with, or follows, a reset edge is discarded. Array contents are not cleared.
- Reset has priority over every other event at the same edge.

## Timing
- Strobe accepted at edge E0 (cycle 0 in IDLE).
- Access commits at edge E0+WAIT; MReady high and MDataOut valid during cycle WAIT+1 (after that edge).
- Request-to-ready latency: WAIT+1 cycles. WAIT=4 gives MReady in cycle 5.
- Minimum request spacing: WAIT+2 cycles (strobe, WAIT busy, DONE, then IDLE sampling).
- MReady, MBusy, MDataOut are all registered; no combinational input-to-output path.
- Read-after-write to the same index returns the new data, since the write commits before DONE.

## Structure
- Shared package mem_pkg: state enum {IDLE, BUSY, DONE}; default WAIT/DEPTH constants; counter width constant (4 bits).
- One sub-module, mem_array: single-port synchronous word RAM (DEPTH x 32, write-enable, registered read) instantiated by the controller FSM.
- Counter and request registers live in the top module.

## Test plan
- Reset: hold Reset=0 for 2 cycles with MStrobe=1 -> MReady=0, MBusy=0, MDataOut=0, no access started. Release -> the first strobe is accepted the next edge.
- Write then read, WAIT=4: write 32'hDEADBEEF at 0x100, then read 0x100 -> MReady in cycle 5 for each; the read returns DEADBEEF.
- Aliasing, DEPTH=4096: write 32'h12345678 at 0x0000_4004 -> a read of 0x0000_0004 and of 0x0000_0007 both return 12345678.
- Strobe in BUSY: accept a read at 0x10; pulse MStrobe with a write to 0x10 during BUSY -> the write is ignored, memory at 0x10 is unchanged, and there is exactly one MReady pulse.
- Back-to-back: MStrobe held high for 20 cycles, WAIT=1 -> MReady pulses every 3 cycles; MBusy is low only on acceptance cycles.
- Reset mid-write: accept a write of 32'hA5A5A5A5 to 0x20, then drive Reset=0 one cycle before the commit edge -> no MReady; a subsequent read of 0x20 returns the old value.
